// File: rtl/branch_predictor.sv
// Direct-mapped, tagged table of 2-bit saturating counters predicting conditional
// branches at fetch, checked against the resolved outcome one stage later in execute.
module branch_predictor #(
    parameter  int PC_WIDTH  = 32,
    parameter  int ENTRIES   = 16,
    parameter  int CNT_WIDTH = 32,
    localparam int IDX_BITS  = $clog2(ENTRIES),
    localparam int TAG_BITS  = PC_WIDTH - 2 - IDX_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [PC_WIDTH-1:0]  i_if_pc,
    input  logic                 i_if_is_br,
    output logic                 o_if_pred_taken,
    input  logic [PC_WIDTH-1:0]  i_x_pc,
    input  logic                 i_x_is_br,
    input  logic                 i_x_br_taken,
    output logic                 o_x_pred_taken,
    output logic                 o_br_pred_correct,
    output logic [CNT_WIDTH-1:0] o_br_count,
    output logic [CNT_WIDTH-1:0] o_mispred_count
);

    logic [ENTRIES-1:0]   r_valid;
    logic [TAG_BITS-1:0]  r_tag [ENTRIES];
    logic [1:0]           r_cnt [ENTRIES];
    logic                 r_x_pred;
    logic [CNT_WIDTH-1:0] r_br_count;
    logic [CNT_WIDTH-1:0] r_mispred_count;

    logic [IDX_BITS-1:0]  w_if_idx;
    logic [TAG_BITS-1:0]  w_if_tag;
    logic [IDX_BITS-1:0]  w_x_idx;
    logic [TAG_BITS-1:0]  w_x_tag;
    logic                 w_if_hit;
    logic                 w_x_hit;
    logic                 w_if_pred;
    logic                 w_correct;
    logic                 w_update;
    logic [1:0]           w_cnt_cur;
    logic [1:0]           w_cnt_next;
    logic [3:0]           w_unused_pc_bits;

    // Instructions are word aligned, so the low two PC bits carry no information.
    assign w_unused_pc_bits = {i_if_pc[1:0], i_x_pc[1:0]};

    assign w_if_idx = i_if_pc[IDX_BITS+1:2];
    assign w_if_tag = i_if_pc[PC_WIDTH-1:IDX_BITS+2];
    assign w_x_idx  = i_x_pc[IDX_BITS+1:2];
    assign w_x_tag  = i_x_pc[PC_WIDTH-1:IDX_BITS+2];

    assign w_if_hit  = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_x_hit   = r_valid[w_x_idx] && (r_tag[w_x_idx] == w_x_tag);
    assign w_if_pred = i_if_is_br && w_if_hit && r_cnt[w_if_idx][1];
    assign w_correct = !i_x_is_br || (r_x_pred == i_x_br_taken);
    assign w_update  = i_x_is_br && !i_stall;

    always_comb begin
        w_cnt_cur  = r_cnt[w_x_idx];
        w_cnt_next = w_cnt_cur;
        if (i_x_br_taken) begin
            if (w_cnt_cur != 2'b11) w_cnt_next = w_cnt_cur + 2'b01;
        end else begin
            if (w_cnt_cur != 2'b00) w_cnt_next = w_cnt_cur - 2'b01;
        end
    end

    // Lookup reads the pre-update table: a same-cycle write to the fetched index is not bypassed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid         <= '0;
            r_x_pred        <= 1'b0;
            r_br_count      <= '0;
            r_mispred_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i] <= '0;
                r_cnt[i] <= 2'b01;
            end
        end else begin
            if (!i_stall) r_x_pred <= i_flush ? 1'b0 : w_if_pred;
            if (w_update) begin
                if (w_x_hit) begin
                    r_cnt[w_x_idx] <= w_cnt_next;
                end else begin
                    r_valid[w_x_idx] <= 1'b1;
                    r_tag[w_x_idx]   <= w_x_tag;
                    r_cnt[w_x_idx]   <= i_x_br_taken ? 2'b10 : 2'b01;
                end
                r_br_count <= r_br_count + CNT_WIDTH'(1);
                if (!w_correct) r_mispred_count <= r_mispred_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_if_pred_taken   = w_if_pred;
    assign o_x_pred_taken    = r_x_pred;
    assign o_br_pred_correct = w_correct;
    assign o_br_count        = r_br_count;
    assign o_mispred_count   = r_mispred_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected execute-stage predictions go through a
// scoreboard queue; statistics counters use a narrow width so wrap-around is reachable.
module tb_branch_predictor;

    localparam int PC_W  = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall, flush;
    logic [PC_W-1:0]  if_pc, x_pc;
    logic             if_is_br, x_is_br, x_br_taken;
    logic             if_pred_taken, x_pred_taken, br_pred_correct;
    logic [CNT_W-1:0] br_count, mispred_count;

    int               n_total = 0;
    int               n_pass  = 0;
    logic             sb [$];
    logic             last_x;
    logic [CNT_W-1:0] exp_br, exp_mis;

    branch_predictor #(.PC_WIDTH(PC_W), .ENTRIES(16), .CNT_WIDTH(CNT_W)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_stall           (stall),
        .i_flush           (flush),
        .i_if_pc           (if_pc),
        .i_if_is_br        (if_is_br),
        .o_if_pred_taken   (if_pred_taken),
        .i_x_pc            (x_pc),
        .i_x_is_br         (x_is_br),
        .i_x_br_taken      (x_br_taken),
        .o_x_pred_taken    (x_pred_taken),
        .o_br_pred_correct (br_pred_correct),
        .o_br_count        (br_count),
        .o_mispred_count   (mispred_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle of stimulus, check combinational outputs, clock, then check registered ones.
    task automatic step(input logic [31:0] ipc, input logic ibr,
                        input logic [31:0] xpc, input logic xbr, input logic xtk,
                        input logic st, input logic fl,
                        input logic exp_if, input logic exp_ok);
        logic exp_x;
        if_pc = ipc; if_is_br = ibr;
        x_pc = xpc; x_is_br = xbr; x_br_taken = xtk;
        stall = st; flush = fl;
        #1;
        check("if_pred_taken", 32'(if_pred_taken), 32'(exp_if));
        check("br_pred_correct", 32'(br_pred_correct), 32'(exp_ok));
        if (!st) last_x = fl ? 1'b0 : exp_if;
        sb.push_back(last_x);
        if (xbr && !st) begin
            exp_br++;
            if (!exp_ok) exp_mis++;
        end
        @(posedge clk); #1;
        exp_x = sb.pop_front();
        check("x_pred_taken", 32'(x_pred_taken), 32'(exp_x));
        check("br_count", 32'(br_count), 32'(exp_br));
        check("mispred_count", 32'(mispred_count), 32'(exp_mis));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        if_pc = 32'h100; if_is_br = 1'b1;
        x_pc = '0; x_is_br = 1'b0; x_br_taken = 1'b0;
        last_x = 1'b0; exp_br = '0; exp_mis = '0;
        #12;
        check("rst_if_pred", 32'(if_pred_taken), 32'd0);
        check("rst_correct", 32'(br_pred_correct), 32'd1);
        check("rst_x_pred", 32'(x_pred_taken), 32'd0);
        check("rst_br_count", 32'(br_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // First sighting of 0x100: miss, mispredict, allocate weak-taken
        step(32'h100, 1, 32'h000, 0, 0, 0, 0, 0, 1);
        step(32'h000, 0, 32'h100, 1, 1, 0, 0, 0, 0);
        step(32'h100, 1, 32'h000, 0, 0, 0, 0, 1, 1);

        // 0x200: taken x4 saturates, then two not-taken drop to weak not-taken
        step(32'h000, 0, 32'h200, 1, 1, 0, 0, 0, 1);
        step(32'h000, 0, 32'h200, 1, 1, 0, 0, 0, 0);
        step(32'h000, 0, 32'h200, 1, 1, 0, 0, 0, 0);
        step(32'h000, 0, 32'h200, 1, 1, 0, 0, 0, 0);
        step(32'h200, 1, 32'h200, 1, 0, 0, 0, 1, 1);
        step(32'h200, 1, 32'h200, 1, 0, 0, 0, 1, 0);
        step(32'h200, 1, 32'h000, 0, 0, 0, 0, 0, 1);

        // Alias: 0x140 shares index 0 with 0x100 and evicts it
        step(32'h000, 0, 32'h100, 1, 1, 0, 0, 0, 0);
        step(32'h100, 1, 32'h140, 1, 0, 0, 0, 1, 1);
        step(32'h100, 1, 32'h000, 0, 0, 0, 0, 0, 1);
        step(32'h140, 1, 32'h000, 0, 0, 0, 0, 0, 1);

        // Same-cycle lookup and allocate of 0x300: no bypass
        step(32'h300, 1, 32'h300, 1, 1, 0, 0, 0, 0);
        step(32'h300, 1, 32'h000, 0, 0, 0, 0, 1, 1);

        // Stall freezes pipeline register, table and counters
        for (int i = 0; i < 3; i++)
            step(32'h400, 1, 32'h300, 1, 1, 1, 0, 0, 1);
        // Flush kills a taken prediction; counter 10 -> 01 proves stall blocked training
        step(32'h300, 1, 32'h300, 1, 0, 0, 1, 1, 0);
        step(32'h300, 1, 32'h300, 1, 1, 0, 0, 0, 0);
        step(32'h000, 0, 32'h000, 0, 1, 0, 0, 0, 1);

        // Asynchronous reset between edges
        if_pc = 32'h300; if_is_br = 1'b1; x_is_br = 1'b0;
        #1;
        check("pre_rst_if_pred", 32'(if_pred_taken), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_if_pred", 32'(if_pred_taken), 32'd0);
        check("async_rst_br_count", 32'(br_count), 32'd0);
        check("async_rst_mispred", 32'(mispred_count), 32'd0);
        check("async_rst_correct", 32'(br_pred_correct), 32'd1);
        @(posedge clk); #1;
        check("held_rst_x_pred", 32'(x_pred_taken), 32'd0);
        rst = 1'b0;
        sb.delete();
        last_x = 1'b0; exp_br = '0; exp_mis = '0;
        @(posedge clk); #1;
        step(32'h300, 1, 32'h000, 0, 0, 0, 0, 0, 1);

        // Counter wrap: 255 correctly-predicted not-taken branches, then one more
        if_is_br = 1'b0; x_pc = 32'h500; x_is_br = 1'b1; x_br_taken = 1'b0;
        for (int i = 0; i < 255; i++) begin
            @(posedge clk); #1;
            exp_br++;
        end
        check("pre_wrap_br_count", 32'(br_count), 32'(exp_br));
        check("pre_wrap_mispred", 32'(mispred_count), 32'(exp_mis));
        step(32'h000, 0, 32'h500, 1, 1, 0, 0, 0, 0);
        check("wrapped_br_count", 32'(br_count), 32'd0);
        step(32'h500, 1, 32'h000, 0, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
